telemetry_tx: RTL and testbench
===============================

# telemetry_tx

Periodic multi-channel telemetry serializer for the eBike controller. Snapshots NUM_CH raw sensor words (e.g. batt, curr, torque, incline) and transmits them as a framed, checksummed UART packet on the top-level `TX` pin. It sits beside the A2D/sensor-conditioning blocks and replaces ad-hoc debug taps with a parametrised, self-timed link.

## Interface
- `NUM_CH`, 3, number of channels per frame (1..16)
- `DATA_W`, 12, bits per channel (1..32); sent as B = ceil(DATA_W/8) bytes
- `BAUD_DIV`, 434, clk cycles per UART bit (50 MHz / 115200); minimum 2
- `FAST_SIM`, 1, frame period 2^12 cycles when 1, 2^22 cycles when 0
- `HEADER`, 8'hA5, frame sync byte

- `clk`  in  1  system clock, 50 MHz
- `rst_n`  in  1  asynchronous active-low reset
- `en`  in  1  enables the periodic trigger
- `force_tx`  in  1  single-cycle request to send a frame now
- `ch_data`  in  NUM_CH*DATA_W  packed channel words; channel 0 in `[DATA_W-1:0]`
- `TX`  out  1  UART serial out, 8N1, idle high
- `busy`  out  1  frame in progress
- `frame_done`  out  1  one-cycle pulse at end of frame
- `ovr`  out  1  one-cycle pulse when a periodic trigger is dropped

## Operation
- Period counter: counts while `en`=1, held at 0 while `en`=0; on reaching PERIOD-1 it generates a periodic trigger and wraps to 0.
- Trigger = periodic trigger OR `force_tx`. Accepted only when `busy`=0. Periodic trigger while busy -> dropped, `ovr` pulses that cycle. `force_tx` while busy -> silently ignored.
- On acceptance, `ch_data` is latched in full; later input changes do not affect the frame.
- Frame byte order: HEADER; then for ch = 0..NUM_CH-1, B bytes MSB first, zero-padded above DATA_W; then checksum. Length L = 2 + NUM_CH*B.
- Checksum = two's complement (mod 256) of the sum of all channel bytes; header excluded. Sum of channel bytes + checksum = 0 mod 256.
- FSM: IDLE -> HDR -> DATA (byte index 0..NUM_CH*B-1) -> CSUM -> IDLE. Each state issues one byte to the UART and advances on its done pulse.
- UART byte: start bit (0), 8 data bits LSB first, stop bit (1); each BAUD_DIV cycles. No idle gap between bytes of a frame.
- `en` deassertion mid-frame: the current frame completes; only the counter is cleared.
- Asynchronous reset mid-frame: the frame is abandoned immediately, and all outputs return to their reset values.

## Timing
- Reset values: `TX`=1, `busy`=0, `frame_done`=0, `ovr`=0, period counter 0, FSM IDLE.
- Trigger accepted in cycle t -> `busy`=1 and `TX`=0 (start bit) from cycle t+1.
- Frame duration exactly L*10*BAUD_DIV cycles from the start-bit edge to the end of the final stop bit.
- `frame_done` pulses in the cycle after the last stop-bit cycle. `busy` falls in the same cycle. A trigger in that cycle is accepted, and back-to-back frames are gap-free apart from that one cycle.
- Periodic trigger and `force_tx` in the same idle cycle -> one frame; the counter still wraps.

## Structure
- Package `telemetry_pkg`: FSM state enum typedef `tlm_state_t` {IDLE, HDR, DATA, CSUM}, default HEADER constant, and a function computing B from DATA_W.
- Sub-module `uart_tx` (parameter BAUD_DIV; ports clk, rst_n, trmt, tx_data[7:0], TX, tx_done): baud counter plus 10-bit shift register. `tx_done` pulses after the stop bit.
- The top FSM owns the snapshot register, byte mux, running checksum accumulator and period counter.

## Test plan
- NUM_CH=3, DATA_W=12, BAUD_DIV=4: pulse `force_tx` with ch0=0x0FF, ch1=0x123, ch2=0xABC -> TX decodes A5 00 FF 01 23 0A BC 17. `busy` is high for 320 cycles, and `frame_done` pulses once.
- Change `ch_data` to all-ones one cycle after acceptance -> transmitted bytes unchanged from the snapshot.
- `en`=1, FAST_SIM=1, BAUD_DIV=434, NUM_CH=3 (frame 34720 cycles > 4096) -> successive periodic triggers fall during busy, and `ovr` pulses. Frames start only when idle, with no corruption.
- `force_tx` held for 3 cycles while idle -> exactly one frame. `force_tx` mid-frame -> no effect, no `ovr`.
- Assert `rst_n` low during DATA byte 2 -> `TX`=1, `busy`=0 immediately. After release, `force_tx` produces a complete, correct frame.
- DATA_W=4, NUM_CH=1, ch0=0xF -> frame A5 0F F1, with B=1.

Source files
------------

// File: rtl/telemetry_pkg.sv
// Shared types and constants for the telemetry serializer: FSM state encoding,
// default sync byte and the per-channel byte-count helper.
package telemetry_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        DATA = 2'd2,
        CSUM = 2'd3
    } tlm_state_t;

    localparam logic [7:0] DEF_HEADER = 8'hA5;

    function automatic int bytes_per_ch(input int data_w);
        return (data_w + 32'sd7) / 32'sd8;
    endfunction

endpackage

// File: rtl/telemetry_tx_if.sv
// Control/data bundle between the telemetry serializer and its host: trigger
// inputs, packed channel words and the serial/status outputs.
interface telemetry_tx_if #(
    parameter int NUM_CH = 3,
    parameter int DATA_W = 12
);
    logic                       en;
    logic                       force_tx;
    logic [NUM_CH*DATA_W-1:0]   ch_data;
    logic                       TX;
    logic                       busy;
    logic                       frame_done;
    logic                       ovr;

    modport master (
        output en, force_tx, ch_data,
        input  TX, busy, frame_done, ovr
    );

    modport slave (
        input  en, force_tx, ch_data,
        output TX, busy, frame_done, ovr
    );
endinterface

// File: rtl/uart_tx.sv
// 8N1 UART transmitter. tx_done is high during the final stop-bit cycle so a
// new byte loaded on trmt in that cycle follows with no idle gap.
module uart_tx #(
    parameter int BAUD_DIV = 434
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       trmt,
    input  logic [7:0] tx_data,
    output logic       TX,
    output logic       tx_done
);
    localparam int CW = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] BAUD_PRE  = CW'(BAUD_DIV - 2);

    logic [9:0]    shift_q, shift_d;
    logic [CW-1:0] baud_q, baud_d;
    logic [3:0]    bit_q, bit_d;
    logic          act_q, act_d;
    logic          done_q, done_d;

    // Next-state logic for baud timing and bit shifting.
    always_comb begin
        shift_d = shift_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        act_d   = act_q;
        done_d  = 1'b0;
        if (trmt) begin
            shift_d = {1'b1, tx_data, 1'b0};
            baud_d  = '0;
            bit_d   = 4'd0;
            act_d   = 1'b1;
        end else if (act_q) begin
            // Registered one cycle early so it lines up with the last stop-bit cycle.
            done_d = (bit_q == 4'd9) && (baud_q == BAUD_PRE);
            if (baud_q == BAUD_LAST) begin
                baud_d  = '0;
                shift_d = {1'b1, shift_q[9:1]};
                if (bit_q == 4'd9) begin
                    act_d = 1'b0;
                end else begin
                    bit_d = bit_q + 4'd1;
                end
            end else begin
                baud_d = baud_q + CW'(1);
            end
        end else begin
            act_d = 1'b0;
        end
    end

    // State registers; the shifter idles at all ones so TX rests high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q <= 10'h3FF;
            baud_q  <= '0;
            bit_q   <= 4'd0;
            act_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            shift_q <= shift_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            act_q   <= act_d;
            done_q  <= done_d;
        end
    end

    assign TX      = shift_q[0];
    assign tx_done = done_q;

endmodule

// File: rtl/telemetry_tx.sv
// Periodic multi-channel telemetry framer: snapshots channel words and sends
// HEADER, channel bytes (MSB first) and a two's-complement checksum over UART.
module telemetry_tx
    import telemetry_pkg::*;
#(
    parameter int         NUM_CH   = 3,
    parameter int         DATA_W   = 12,
    parameter int         BAUD_DIV = 434,
    parameter int         FAST_SIM = 1,
    parameter logic [7:0] HEADER   = DEF_HEADER
) (
    input  logic          clk,
    input  logic          rst_n,
    telemetry_tx_if.slave bus
);
    localparam int B   = bytes_per_ch(DATA_W);
    localparam int CHW = B * 8;
    localparam int NCB = NUM_CH * B;
    localparam int FW  = NCB * 8;
    localparam int PW  = (FAST_SIM != 0) ? 12 : 22;
    localparam int IW  = (NCB > 1) ? $clog2(NCB) : 1;
    localparam logic [IW-1:0] IDX_LAST = IW'(NCB - 1);

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_HDR  = HDR;
    localparam logic [1:0] ST_DATA = DATA;
    localparam logic [1:0] ST_CSUM = CSUM;

    logic [1:0]    state_q, state_d;
    logic [FW-1:0] frame_q, frame_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [7:0]    csum_q, csum_d;
    logic [PW-1:0] per_q, per_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          ovr_q, ovr_d;

    logic [FW-1:0] snap_s;
    logic [7:0]    cur_byte_s, tx_byte_s;
    logic          per_trig_s, accept_s, trmt_s, tx_done_s, tx_s;

    // Channel 0 lands in the top byte(s) so the frame shifts out left-to-right.
    for (genvar c = 0; c < NUM_CH; c++) begin : g_pad
        assign snap_s[FW-1-c*CHW -: CHW] = CHW'(bus.ch_data[c*DATA_W +: DATA_W]);
    end

    assign cur_byte_s = frame_q[FW-1 -: 8];
    assign per_trig_s = bus.en && (&per_q);
    assign accept_s   = (per_trig_s || bus.force_tx) && !busy_q;

    // Frame sequencing, checksum accumulation and period counting.
    always_comb begin
        state_d   = state_q;
        frame_d   = frame_q;
        idx_d     = idx_q;
        csum_d    = csum_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        trmt_s    = 1'b0;
        tx_byte_s = HEADER;
        ovr_d     = per_trig_s && busy_q;
        if (bus.en) begin
            per_d = per_q + PW'(1);
        end else begin
            per_d = '0;
        end
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    trmt_s  = 1'b1;
                    frame_d = snap_s;
                    csum_d  = 8'h00;
                    idx_d   = '0;
                    busy_d  = 1'b1;
                    state_d = ST_HDR;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_HDR: begin
                if (tx_done_s) begin
                    trmt_s    = 1'b1;
                    tx_byte_s = cur_byte_s;
                    csum_d    = csum_q + cur_byte_s;
                    frame_d   = frame_q << 4'd8;
                    idx_d     = '0;
                    state_d   = ST_DATA;
                end else begin
                    state_d = ST_HDR;
                end
            end
            ST_DATA: begin
                if (tx_done_s) begin
                    trmt_s = 1'b1;
                    if (idx_q == IDX_LAST) begin
                        tx_byte_s = 8'h00 - csum_q;
                        state_d   = ST_CSUM;
                    end else begin
                        tx_byte_s = cur_byte_s;
                        csum_d    = csum_q + cur_byte_s;
                        frame_d   = frame_q << 4'd8;
                        idx_d     = idx_q + IW'(1);
                    end
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_CSUM: begin
                if (tx_done_s) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_CSUM;
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Framer state and registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            frame_q <= '0;
            idx_q   <= '0;
            csum_q  <= 8'h00;
            per_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            frame_q <= frame_d;
            idx_q   <= idx_d;
            csum_q  <= csum_d;
            per_q   <= per_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ovr_q   <= ovr_d;
        end
    end

    uart_tx #(.BAUD_DIV(BAUD_DIV)) u_uart (
        .clk     (clk),
        .rst_n   (rst_n),
        .trmt    (trmt_s),
        .tx_data (tx_byte_s),
        .TX      (tx_s),
        .tx_done (tx_done_s)
    );

    assign bus.TX         = tx_s;
    assign bus.busy       = busy_q;
    assign bus.frame_done = done_q;
    assign bus.ovr        = ovr_q;

endmodule

// File: tb/tb_telemetry_tx.sv
// Directed bench for telemetry_tx: three configurations (3x12 bit fast baud,
// 3x12 bit slow baud for overrun, 1x4 bit), UART-decoded frames vs. tables.
module tb_telemetry_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a_n, rst_b_n, rst_c_n;

    telemetry_tx_if #(.NUM_CH(3), .DATA_W(12)) bus_a ();
    telemetry_tx_if #(.NUM_CH(3), .DATA_W(12)) bus_b ();
    telemetry_tx_if #(.NUM_CH(1), .DATA_W(4))  bus_c ();

    telemetry_tx #(.NUM_CH(3), .DATA_W(12), .BAUD_DIV(4), .FAST_SIM(1), .HEADER(8'hA5))
        dut_a (.clk(clk), .rst_n(rst_a_n), .bus(bus_a));
    telemetry_tx #(.NUM_CH(3), .DATA_W(12), .BAUD_DIV(52), .FAST_SIM(1), .HEADER(8'hA5))
        dut_b (.clk(clk), .rst_n(rst_b_n), .bus(bus_b));
    telemetry_tx #(.NUM_CH(1), .DATA_W(4), .BAUD_DIV(2), .FAST_SIM(1), .HEADER(8'hA5))
        dut_c (.clk(clk), .rst_n(rst_c_n), .bus(bus_c));

    int checks = 0;
    int failures = 0;

    logic [7:0] q0[$];
    logic [7:0] q1[$];
    logic [7:0] q2[$];
    int err0 = 0, err1 = 0, err2 = 0;
    int busy_a = 0, done_a = 0, ovr_a = 0;
    int busy_b = 0, done_b = 0, ovr_b = 0;
    int busy_c = 0, done_c = 0;

    always @(negedge clk) begin
        if (bus_a.busy === 1'b1) busy_a++;
        if (bus_a.frame_done === 1'b1) done_a++;
        if (bus_a.ovr === 1'b1) ovr_a++;
        if (bus_b.busy === 1'b1) busy_b++;
        if (bus_b.frame_done === 1'b1) done_b++;
        if (bus_b.ovr === 1'b1) ovr_b++;
        if (bus_c.busy === 1'b1) busy_c++;
        if (bus_c.frame_done === 1'b1) done_c++;
    end

    function automatic logic tx_of(input int w);
        case (w)
            0:       return bus_a.TX;
            1:       return bus_b.TX;
            default: return bus_c.TX;
        endcase
    endfunction

    function automatic logic done_of(input int w);
        case (w)
            0:       return bus_a.frame_done;
            1:       return bus_b.frame_done;
            default: return bus_c.frame_done;
        endcase
    endfunction

    function automatic int qsize(input int w);
        case (w)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic logic [7:0] qget(input int w, input int i);
        case (w)
            0:       return q0[i];
            1:       return q1[i];
            default: return q2[i];
        endcase
    endfunction

    function automatic int err_of(input int w);
        case (w)
            0:       return err0;
            1:       return err1;
            default: return err2;
        endcase
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
        end
    endtask

    // UART receiver: samples mid-bit on falling clock edges.
    task automatic monitor(input int w, input int bd);
        logic [7:0] b;
        logic ok;
        forever begin
            @(negedge clk);
            if (tx_of(w) === 1'b0) begin
                ok = 1'b1;
                repeat (bd / 2) @(negedge clk);
                if (tx_of(w) !== 1'b0) ok = 1'b0;
                for (int i = 0; i < 8; i++) begin
                    repeat (bd) @(negedge clk);
                    b[i] = tx_of(w);
                end
                repeat (bd) @(negedge clk);
                if (tx_of(w) !== 1'b1) ok = 1'b0;
                case (w)
                    0: begin q0.push_back(b); if (!ok) err0++; end
                    1: begin q1.push_back(b); if (!ok) err1++; end
                    default: begin q2.push_back(b); if (!ok) err2++; end
                endcase
            end
        end
    endtask

    initial monitor(0, 4);
    initial monitor(1, 52);
    initial monitor(2, 2);

    task automatic wait_done(input int w, input int limit, input string nm);
        bit seen = 1'b0;
        for (int i = 0; i < limit && !seen; i++) begin
            @(negedge clk);
            if (done_of(w) === 1'b1) seen = 1'b1;
        end
        check({nm, "_done_seen"}, {63'd0, seen}, 64'd1);
    endtask

    task automatic check_frame(input int w, input int base, input int ebase, input int n,
                               input logic [63:0] exp, input string nm);
        logic [63:0] e;
        check({nm, "_len"}, qsize(w) - base, n);
        check({nm, "_framing"}, err_of(w) - ebase, 64'd0);
        for (int k = 0; k < n; k++) begin
            e = exp >> (8 * (n - 1 - k));
            if (qsize(w) > base + k)
                check($sformatf("%s_byte%0d", nm, k), {56'd0, qget(w, base + k)}, {56'd0, e[7:0]});
        end
    endtask

    typedef struct {
        logic [35:0] data;
        logic [63:0] exp;
        bit          corrupt;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int base, eb, bb, db, ob, ovb;
        bit seen;
        vecs[0] = '{36'hABC1230FF, 64'hA500FF01230ABC17, 1'b0};
        vecs[1] = '{36'h000000000, 64'hA500000000000000, 1'b0};
        vecs[2] = '{36'hFFFFFFFFF, 64'hA50FFF0FFF0FFFD6, 1'b0};
        vecs[3] = '{36'h7FE001800, 64'hA50800000107FEF2, 1'b0};
        vecs[4] = '{36'h3C30A55A5, 64'hA505A500A503C3EB, 1'b0};
        vecs[5] = '{36'hABC1230FF, 64'hA500FF01230ABC17, 1'b1};

        rst_a_n = 1'b0; rst_b_n = 1'b0; rst_c_n = 1'b0;
        bus_a.en = 1'b0; bus_a.force_tx = 1'b0; bus_a.ch_data = '0;
        bus_b.en = 1'b0; bus_b.force_tx = 1'b0; bus_b.ch_data = '0;
        bus_c.en = 1'b0; bus_c.force_tx = 1'b0; bus_c.ch_data = '0;
        repeat (3) @(negedge clk);
        check("rst_tx", {63'd0, bus_a.TX}, 64'd1);
        check("rst_busy", {63'd0, bus_a.busy}, 64'd0);
        check("rst_frame_done", {63'd0, bus_a.frame_done}, 64'd0);
        check("rst_ovr", {63'd0, bus_a.ovr}, 64'd0);
        rst_a_n = 1'b1; rst_b_n = 1'b1; rst_c_n = 1'b1;
        repeat (20) @(negedge clk);

        // Table of forced frames on the fast-baud instance.
        for (int i = 0; i < 6; i++) begin
            bus_a.ch_data = vecs[i].data;
            base = q0.size(); eb = err0; bb = busy_a; db = done_a;
            @(negedge clk); bus_a.force_tx = 1'b1;
            @(negedge clk); bus_a.force_tx = 1'b0;
            check($sformatf("v%0d_busy_latency", i), {63'd0, bus_a.busy}, 64'd1);
            check($sformatf("v%0d_start_bit", i), {63'd0, bus_a.TX}, 64'd0);
            if (vecs[i].corrupt) bus_a.ch_data = '1;
            wait_done(0, 400, $sformatf("v%0d", i));
            repeat (3) @(negedge clk);
            check($sformatf("v%0d_busy_cycles", i), busy_a - bb, 64'd320);
            check($sformatf("v%0d_done_pulses", i), done_a - db, 64'd1);
            check_frame(0, base, eb, 8, vecs[i].exp, $sformatf("v%0d", i));
            repeat (5) @(negedge clk);
        end

        // force_tx held for three idle cycles yields a single frame.
        bus_a.ch_data = vecs[0].data;
        base = q0.size(); eb = err0; bb = busy_a; db = done_a;
        @(negedge clk); bus_a.force_tx = 1'b1;
        repeat (3) @(negedge clk);
        bus_a.force_tx = 1'b0;
        wait_done(0, 400, "held");
        repeat (40) @(negedge clk);
        check("held_done_pulses", done_a - db, 64'd1);
        check("held_busy_cycles", busy_a - bb, 64'd320);
        check_frame(0, base, eb, 8, vecs[0].exp, "held");

        // force_tx mid-frame is ignored without an overrun pulse.
        bus_a.ch_data = vecs[3].data;
        base = q0.size(); eb = err0; db = done_a; ob = ovr_a;
        @(negedge clk); bus_a.force_tx = 1'b1;
        @(negedge clk); bus_a.force_tx = 1'b0;
        repeat (100) @(negedge clk);
        bus_a.force_tx = 1'b1;
        @(negedge clk); bus_a.force_tx = 1'b0;
        wait_done(0, 400, "midforce");
        repeat (40) @(negedge clk);
        check("midforce_done_pulses", done_a - db, 64'd1);
        check("midforce_ovr", ovr_a - ob, 64'd0);
        check("midforce_idle_after", {63'd0, bus_a.busy}, 64'd0);
        check_frame(0, base, eb, 8, vecs[3].exp, "midforce");

        // Asynchronous reset during the third channel byte abandons the frame.
        bus_a.ch_data = vecs[4].data;
        db = done_a;
        @(negedge clk); bus_a.force_tx = 1'b1;
        @(negedge clk); bus_a.force_tx = 1'b0;
        repeat (140) @(negedge clk);
        #1 rst_a_n = 1'b0;
        #1;
        check("arst_tx", {63'd0, bus_a.TX}, 64'd1);
        check("arst_busy", {63'd0, bus_a.busy}, 64'd0);
        repeat (3) @(negedge clk);
        rst_a_n = 1'b1;
        repeat (60) @(negedge clk);
        check("arst_no_done", done_a - db, 64'd0);
        bus_a.ch_data = vecs[0].data;
        base = q0.size(); eb = err0;
        @(negedge clk); bus_a.force_tx = 1'b1;
        @(negedge clk); bus_a.force_tx = 1'b0;
        wait_done(0, 400, "postrst");
        repeat (3) @(negedge clk);
        check_frame(0, base, eb, 8, vecs[0].exp, "postrst");

        // Single 4-bit channel: one byte per channel.
        bus_c.ch_data = 4'hF;
        base = q2.size(); eb = err2; bb = busy_c;
        @(negedge clk); bus_c.force_tx = 1'b1;
        @(negedge clk); bus_c.force_tx = 1'b0;
        wait_done(2, 200, "c");
        repeat (3) @(negedge clk);
        check("c_busy_cycles", busy_c - bb, 64'd60);
        check_frame(2, base, eb, 3, 64'h0000000000A50FF1, "c");

        // Periodic triggering with a frame longer than the period.
        bus_b.ch_data = vecs[3].data;
        base = q1.size(); eb = err1; db = done_b; ovb = ovr_b;
        @(negedge clk); bus_b.en = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 5000 && !seen; i++) begin
            @(negedge clk);
            if (bus_b.busy === 1'b1) seen = 1'b1;
        end
        check("b_first_start", {63'd0, seen}, 64'd1);
        seen = 1'b0;
        for (int i = 0; i < 5000 && !seen; i++) begin
            @(negedge clk);
            if (bus_b.ovr === 1'b1) seen = 1'b1;
        end
        check("b_ovr_seen", {63'd0, seen}, 64'd1);
        check("b_busy_at_ovr", {63'd0, bus_b.busy}, 64'd1);
        wait_done(1, 5000, "b1");
        repeat (3) @(negedge clk);
        check_frame(1, base, eb, 8, vecs[3].exp, "b1");
        base = q1.size(); eb = err1;
        seen = 1'b0;
        for (int i = 0; i < 5000 && !seen; i++) begin
            @(negedge clk);
            if (bus_b.busy === 1'b1) seen = 1'b1;
        end
        check("b_second_start", {63'd0, seen}, 64'd1);
        wait_done(1, 5000, "b2");
        bus_b.en = 1'b0;
        repeat (3) @(negedge clk);
        check_frame(1, base, eb, 8, vecs[3].exp, "b2");
        check("b_done_pulses", done_b - db, 64'd2);
        check("b_ovr_pulses", ovr_b - ovb, 64'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
